// File: rtl/timing_loop_ctrl.sv
// Symbol timing recovery sequencer: windows mean |TED error| per mk strobe and
// steps IDLE -> FLUSH -> ACQ <-> TRACK, driving loop-filter clear, gain select and lock.
module timing_loop_ctrl #(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           WIN_LOG2    = 6,
  parameter logic [DATA_WIDTH-1:0] LOCK_THR    = 16'd512,
  parameter logic [DATA_WIDTH-1:0] UNLOCK_THR  = 16'd2048,
  parameter int unsigned           LOCK_WINS   = 4,
  parameter int unsigned           UNLOCK_WINS = 2,
  parameter int unsigned           ACQ_TIMEOUT = 32,
  parameter int unsigned           FLUSH_CYC   = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         enable,
  input  logic                         mk,
  input  logic signed [DATA_WIDTH-1:0] ted_err,
  output logic                         lf_clr,
  output logic                         gain_sel,
  output logic                         locked,
  output logic                         sym_valid,
  output logic        [DATA_WIDTH-1:0] err_avg,
  output logic        [1:0]            state,
  output logic        [7:0]            retry_cnt
);

  localparam int unsigned ACC_W = DATA_WIDTH + WIN_LOG2;
  localparam int unsigned GW    = $clog2(LOCK_WINS + 1);
  localparam int unsigned BW    = $clog2(UNLOCK_WINS + 1);
  localparam int unsigned WW    = $clog2(ACQ_TIMEOUT + 1);
  localparam int unsigned FW    = $clog2(FLUSH_CYC + 1);

  localparam logic [GW-1:0] GOOD_LAST  = GW'(LOCK_WINS - 1);
  localparam logic [BW-1:0] BAD_LAST   = BW'(UNLOCK_WINS - 1);
  localparam logic [WW-1:0] WIN_LAST   = WW'(ACQ_TIMEOUT - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    ACQ   = 2'd2,
    TRACK = 2'd3
  } state_t;

  state_t                st, st_n;
  logic [FW-1:0]         flush_cnt, flush_n;
  logic [ACC_W-1:0]      acc, acc_n;
  logic [WIN_LOG2-1:0]   sym_cnt, sym_n;
  logic [WW-1:0]         win_cnt, win_n;
  logic [GW-1:0]         good_cnt, good_n;
  logic [BW-1:0]         bad_cnt, bad_n;
  logic [DATA_WIDTH-1:0] avg_n;
  logic [7:0]            retry_n;
  logic                  lf_clr_n, gain_sel_n, locked_n, sym_valid_n;

  logic [DATA_WIDTH-1:0] abs_err;
  logic [ACC_W-1:0]      sum;
  logic [DATA_WIDTH-1:0] win_avg;
  logic                  win_done, good_win, bad_win, clear;

  // Most-negative input has no positive twin; clamp it to the largest positive value.
  always_comb begin
    if (!ted_err[DATA_WIDTH-1])
      abs_err = ted_err;
    else if (ted_err == {1'b1, {(DATA_WIDTH-1){1'b0}}})
      abs_err = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      abs_err = -ted_err;
  end

  assign sum      = acc + {{WIN_LOG2{1'b0}}, abs_err};
  assign win_avg  = sum[ACC_W-1:WIN_LOG2];
  assign win_done = mk && (sym_cnt == '1);
  assign good_win = win_avg < LOCK_THR;
  assign bad_win  = win_avg > UNLOCK_THR;

  always_comb begin
    st_n      = st;
    flush_n   = flush_cnt;
    acc_n     = acc;
    sym_n     = sym_cnt;
    win_n     = win_cnt;
    good_n    = good_cnt;
    bad_n     = bad_cnt;
    avg_n     = err_avg;
    retry_n   = retry_cnt;
    clear     = 1'b0;

    if (!enable) begin
      st_n  = IDLE;
      clear = 1'b1;
    end else begin
      case (st)
        IDLE: begin
          st_n  = FLUSH;
          clear = 1'b1;
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) st_n = ACQ;
          else                         flush_n = flush_cnt + FW'(1);
        end
        default: begin
          if (mk) begin
            sym_n = sym_cnt + WIN_LOG2'(1);
            acc_n = sum;
            if (win_done) begin
              acc_n = '0;
              avg_n = win_avg;
              if (st == ACQ) begin
                win_n  = win_cnt + WW'(1);
                good_n = good_win ? good_cnt + GW'(1) : '0;
                // Lock takes priority over a timeout landing on the same window.
                if (good_win && good_cnt == GOOD_LAST) begin
                  st_n   = TRACK;
                  good_n = '0;
                  bad_n  = '0;
                  win_n  = '0;
                end else if (win_cnt == WIN_LAST) begin
                  st_n  = FLUSH;
                  clear = 1'b1;
                  if (retry_cnt != '1) retry_n = retry_cnt + 8'd1;
                end
              end else begin
                bad_n = bad_win ? bad_cnt + BW'(1) : '0;
                if (bad_win && bad_cnt == BAD_LAST) begin
                  st_n   = ACQ;
                  good_n = '0;
                  bad_n  = '0;
                  win_n  = '0;
                end
              end
            end
          end
        end
      endcase
    end

    if (clear) begin
      flush_n = '0;
      acc_n   = '0;
      sym_n   = '0;
      win_n   = '0;
      good_n  = '0;
      bad_n   = '0;
    end

    lf_clr_n    = (st_n == FLUSH);
    gain_sel_n  = (st_n == FLUSH) || (st_n == ACQ);
    locked_n    = (st_n == TRACK);
    sym_valid_n = mk && (st == TRACK) && (st_n == TRACK);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st        <= IDLE;
      flush_cnt <= '0;
      acc       <= '0;
      sym_cnt   <= '0;
      win_cnt   <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
      err_avg   <= '0;
      retry_cnt <= '0;
      lf_clr    <= 1'b0;
      gain_sel  <= 1'b0;
      locked    <= 1'b0;
      sym_valid <= 1'b0;
    end else begin
      st        <= st_n;
      flush_cnt <= flush_n;
      acc       <= acc_n;
      sym_cnt   <= sym_n;
      win_cnt   <= win_n;
      good_cnt  <= good_n;
      bad_cnt   <= bad_n;
      err_avg   <= avg_n;
      retry_cnt <= retry_n;
      lf_clr    <= lf_clr_n;
      gain_sel  <= gain_sel_n;
      locked    <= locked_n;
      sym_valid <= sym_valid_n;
    end
  end

  assign state = st;

endmodule

// File: tb/tb_timing_loop_ctrl.sv
// Bench for timing_loop_ctrl: directed phases plus random traffic, checked every
// cycle against a window-queue reference model of the sequencer rules.
module tb_timing_loop_ctrl;

  localparam int WIN         = 8;
  localparam int LOCK_WINS   = 2;
  localparam int UNLOCK_WINS = 2;
  localparam int ACQ_TIMEOUT = 4;
  localparam int FLUSH_CYC   = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic        mk;
  logic [15:0] ted_err;
  logic        lf_clr, gain_sel, locked, sym_valid;
  logic [15:0] err_avg;
  logic [1:0]  state;
  logic [7:0]  retry_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int          m_st, m_flush, m_wins, m_good, m_bad, m_retry;
  logic [15:0] m_avg;
  bit          m_lf, m_gain, m_locked, m_symv;
  int          samp[$];

  timing_loop_ctrl #(
    .DATA_WIDTH (16),
    .WIN_LOG2   (3),
    .LOCK_THR   (16'd512),
    .UNLOCK_THR (16'd2048),
    .LOCK_WINS  (2),
    .UNLOCK_WINS(2),
    .ACQ_TIMEOUT(4),
    .FLUSH_CYC  (8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .enable   (enable),
    .mk       (mk),
    .ted_err  (ted_err),
    .lf_clr   (lf_clr),
    .gain_sel (gain_sel),
    .locked   (locked),
    .sym_valid(sym_valid),
    .err_avg  (err_avg),
    .state    (state),
    .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat_abs(input logic [15:0] e);
    int v;
    v = int'($signed(e));
    if (v == -32768) return 32767;
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [15:0] rand_err(input int cls);
    int mag;
    int v;
    case (cls)
      0:       mag = int'($urandom_range(0, 700));
      1:       mag = int'($urandom_range(300, 3000));
      2:       mag = int'($urandom_range(1500, 32767));
      default: mag = 32768;
    endcase
    v = ($urandom_range(0, 1) == 1) ? -mag : mag;
    return 16'(v);
  endfunction

  task automatic model_reset();
    m_st = 0; m_flush = 0; m_wins = 0; m_good = 0; m_bad = 0; m_retry = 0;
    m_avg = '0; m_lf = 0; m_gain = 0; m_locked = 0; m_symv = 0;
    samp.delete();
  endtask

  task automatic model_step(input bit en, input bit mkv, input logic [15:0] e);
    int nst;
    int sum;
    int avg;
    nst = m_st;
    if (!en) begin
      nst = 0; samp.delete(); m_wins = 0; m_good = 0; m_bad = 0;
    end else begin
      case (m_st)
        0: nst = 1;
        1: begin
          m_flush++;
          if (m_flush == FLUSH_CYC) nst = 2;
        end
        default: if (mkv) begin
          samp.push_back(sat_abs(e));
          if (samp.size() == WIN) begin
            sum = 0;
            foreach (samp[k]) sum += samp[k];
            avg = sum / WIN;
            samp.delete();
            m_avg = 16'(avg);
            if (m_st == 2) begin
              m_wins++;
              m_good = (avg < 512) ? m_good + 1 : 0;
              if (m_good >= LOCK_WINS) begin
                nst = 3; m_good = 0; m_bad = 0; m_wins = 0;
              end else if (m_wins >= ACQ_TIMEOUT) begin
                nst = 1;
                if (m_retry < 255) m_retry++;
              end
            end else begin
              m_bad = (avg > 2048) ? m_bad + 1 : 0;
              if (m_bad >= UNLOCK_WINS) begin
                nst = 2; m_good = 0; m_bad = 0; m_wins = 0;
              end
            end
          end
        end
      endcase
    end
    if (nst == 1 && m_st != 1) begin
      m_flush = 0; samp.delete(); m_wins = 0; m_good = 0; m_bad = 0;
    end
    m_symv   = mkv && (m_st == 3) && (nst == 3);
    m_st     = nst;
    m_lf     = (nst == 1);
    m_gain   = (nst == 1) || (nst == 2);
    m_locked = (nst == 3);
  endtask

  task automatic check_all();
    chk("state",     state,     32'(m_st));
    chk("lf_clr",    lf_clr,    32'(m_lf));
    chk("gain_sel",  gain_sel,  32'(m_gain));
    chk("locked",    locked,    32'(m_locked));
    chk("sym_valid", sym_valid, 32'(m_symv));
    chk("err_avg",   err_avg,   32'(m_avg));
    chk("retry_cnt", retry_cnt, 32'(m_retry));
  endtask

  task automatic cyc(input bit en, input bit mkv, input logic [15:0] e);
    enable  = en;
    mk      = mkv;
    ted_err = e;
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_step(en, mkv, e);
    #1;
    check_all();
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; mk = 1'b0; ted_err = '0;
    model_reset();
    #2;
    check_all();
    #10;
    rstn = 1'b1;

    // enable -> FLUSH for 8 cycles (mk ignored), then ACQ
    cyc(1, 0, 16'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, rand_err(2));
      if (i == 6) chk("plan_flush_lf", lf_clr, 32'd1);
    end
    chk("plan_acq_state", state, 32'd2);
    chk("plan_acq_gain", gain_sel, 32'd1);
    chk("plan_acq_lf", lf_clr, 32'd0);

    // ACQ: strobe every 2 cycles, +/-100 alternating
    for (int i = 0; i < 32; i++) begin
      cyc(1, (i % 2) == 0, ((i / 2) % 2 == 0) ? 16'd100 : 16'hFF9C);
      if (i == 14) chk("plan_avg100", err_avg, 32'd100);
    end
    chk("plan_track_state", state, 32'd3);
    chk("plan_track_locked", locked, 32'd1);
    chk("plan_track_gain", gain_sel, 32'd0);

    // TRACK: constant +3000 drops lock after two windows
    for (int i = 0; i < 16; i++) begin
      cyc(1, 1, 16'd3000);
      if (i == 7) begin
        chk("plan_avg3000", err_avg, 32'd3000);
        chk("plan_still_locked", locked, 32'd1);
      end
    end
    chk("plan_unlock_state", state, 32'd2);
    chk("plan_unlock_locked", locked, 32'd0);
    chk("plan_unlock_symv", sym_valid, 32'd0);

    // ACQ: most-negative error, timeout into FLUSH, then saturate retry_cnt
    for (int i = 0; i < 32; i++) begin
      cyc(1, 1, 16'h8000);
      if (i == 7) chk("plan_avg_sat", err_avg, 32'h7FFF);
    end
    chk("plan_timeout_state", state, 32'd1);
    chk("plan_retry1", retry_cnt, 32'd1);
    for (int i = 0; i < 300 * 40; i++) cyc(1, 1, 16'h8000);
    chk("plan_retry_sat", retry_cnt, 32'd255);
    chk("plan_sat_state", state, 32'd1);

    // ACQ: alternating 100 / 1000 windows never lock
    for (int i = 0; i < 8; i++) cyc(1, 0, 16'd0);
    chk("plan_alt_acq", state, 32'd2);
    for (int w = 0; w < 4; w++)
      for (int s = 0; s < 8; s++) cyc(1, 1, (w % 2 == 0) ? 16'd100 : 16'd1000);
    chk("plan_alt_nolock", state, 32'd1);
    chk("plan_alt_locked", locked, 32'd0);

    // random traffic in biased segments
    for (int seg = 0; seg < 12; seg++) begin
      int cls;
      cls = int'($urandom_range(0, 3));
      for (int i = 0; i < 200; i++) begin
        int c;
        c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : cls;
        cyc($urandom_range(0, 149) != 0, $urandom_range(0, 3) != 0, rand_err(c));
      end
    end

    // disable mid-window in TRACK, then re-enable and confirm a fresh window
    cyc(0, 0, 16'd0);
    cyc(1, 0, 16'd0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 16'd0);
    for (int i = 0; i < 16; i++) cyc(1, 1, 16'd0);
    chk("plan_track2", state, 32'd3);
    for (int i = 0; i < 3; i++) cyc(1, 1, 16'd0);
    cyc(0, 1, 16'd0);
    chk("plan_dis_state", state, 32'd0);
    chk("plan_dis_locked", locked, 32'd0);
    cyc(1, 0, 16'd0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 16'd0);
    for (int i = 0; i < 7; i++) cyc(1, 1, 16'd800);
    chk("plan_partial_hold", err_avg, 32'd0);
    cyc(1, 1, 16'd800);
    chk("plan_fresh_window", err_avg, 32'd800);

    // async reset mid-FLUSH
    cyc(0, 0, 16'd0);
    cyc(1, 0, 16'd0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 16'd50);
    rstn = 1'b0;
    #2;
    model_reset();
    chk("rst_state", state, 32'd0);
    chk("rst_lf", lf_clr, 32'd0);
    chk("rst_gain", gain_sel, 32'd0);
    chk("rst_retry", retry_cnt, 32'd0);
    check_all();
    cyc(1, 1, 16'd50);
    cyc(1, 1, 16'd50);
    #3;
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) cyc(1, 1, 16'd50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
